// File: rtl/ln_interp_if.sv
// Sample, coefficient-load and result signals of the -ln(U1) evaluator.
// Handshake: a beat transfers when pushin (or pushout) is 1 at a rising clk edge; there is no ready/backpressure.
interface ln_interp_if #(
  parameter int fpw  = 63,
  parameter int size = 8
);
  logic            pushin;
  logic [size:0]   fract_lt;
  logic [fpw:0]    delta_denorm;
  logic            twr;
  logic [size:0]   taddr;
  logic [fpw:0]    tc0;
  logic [fpw:0]    tc1;
  logic            tbl_ready;
  logic            pushout;
  logic [fpw:0]    e;
  logic            e_err;

  modport master (
    output pushin, fract_lt, delta_denorm, twr, taddr, tc0, tc1,
    input  tbl_ready, pushout, e, e_err
  );

  modport slave (
    input  pushin, fract_lt, delta_denorm, twr, taddr, tc0, tc1,
    output tbl_ready, pushout, e, e_err
  );
endinterface

// File: rtl/ln_interp.sv
// Piecewise-linear -ln(U1): e = c0[idx] - (c1[idx] * delta) >> dlw, clamped at 0.
// Three register stages (table read, multiply, subtract); the coefficient table is run-time loaded.
module ln_interp #(
  parameter int fpw  = 63,
  parameter int size = 8
) (
  input  logic        clk,
  input  logic        rst,
  ln_interp_if.slave  bus
);
  localparam int dlw   = fpw - size;
  localparam int depth = 2 ** (size + 1);

  logic [fpw:0] t0_mem [depth];
  logic [fpw:0] t1_mem [depth];

  logic             tbl_ready_q, tbl_ready_d;
  logic             s1_vld_q, s1_vld_d;
  logic             s1_err_q, s1_err_d;
  logic [fpw:0]     s1_c0_q, s1_c0_d;
  logic [fpw:0]     s1_c1_q, s1_c1_d;
  logic [dlw-1:0]   s1_dl_q, s1_dl_d;
  logic             s2_vld_q, s2_vld_d;
  logic             s2_err_q, s2_err_d;
  logic [fpw:0]     s2_c0_q, s2_c0_d;
  logic [fpw:0]     s2_prodsh_q, s2_prodsh_d;
  logic             pushout_q, pushout_d;
  logic [fpw:0]     e_q, e_d;
  logic             e_err_q, e_err_d;
  logic [fpw+dlw:0] prod;

  // Upper residual bits are zero by construction upstream and never used.
  logic unused_delta_hi;
  assign unused_delta_hi = ^bus.delta_denorm[fpw:dlw];

  // No reset on the table: contents survive rst, and a same-cycle read sees the old entry.
  always_ff @(posedge clk) begin
    if (bus.twr) begin
      t0_mem[bus.taddr] <= bus.tc0;
      t1_mem[bus.taddr] <= bus.tc1;
    end
  end

  always_comb begin
    tbl_ready_d = tbl_ready_q | (bus.twr && (bus.taddr == {(size+1){1'b1}}));

    s1_vld_d = bus.pushin;
    s1_err_d = s1_err_q;
    s1_c0_d  = s1_c0_q;
    s1_c1_d  = s1_c1_q;
    s1_dl_d  = s1_dl_q;
    if (bus.pushin) begin
      s1_err_d = ~tbl_ready_q;
      s1_c0_d  = t0_mem[bus.fract_lt];
      s1_c1_d  = t1_mem[bus.fract_lt];
      s1_dl_d  = bus.delta_denorm[dlw-1:0];
    end

    prod        = {{dlw{1'b0}}, s1_c1_q} * {{(fpw+1){1'b0}}, s1_dl_q};
    s2_vld_d    = s1_vld_q;
    s2_err_d    = s2_err_q;
    s2_c0_d     = s2_c0_q;
    s2_prodsh_d = s2_prodsh_q;
    if (s1_vld_q) begin
      s2_err_d    = s1_err_q;
      s2_c0_d     = s1_c0_q;
      s2_prodsh_d = prod[fpw+dlw:dlw];
    end

    // e and e_err hold their last values across bubbles.
    pushout_d = s2_vld_q;
    e_d       = e_q;
    e_err_d   = e_err_q;
    if (s2_vld_q) begin
      e_err_d = s2_err_q;
      e_d     = (s2_prodsh_q > s2_c0_q) ? '0 : (s2_c0_q - s2_prodsh_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_ready_q <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_c0_q     <= '0;
      s1_c1_q     <= '0;
      s1_dl_q     <= '0;
      s2_vld_q    <= 1'b0;
      s2_err_q    <= 1'b0;
      s2_c0_q     <= '0;
      s2_prodsh_q <= '0;
      pushout_q   <= 1'b0;
      e_q         <= '0;
      e_err_q     <= 1'b0;
    end else begin
      tbl_ready_q <= tbl_ready_d;
      s1_vld_q    <= s1_vld_d;
      s1_err_q    <= s1_err_d;
      s1_c0_q     <= s1_c0_d;
      s1_c1_q     <= s1_c1_d;
      s1_dl_q     <= s1_dl_d;
      s2_vld_q    <= s2_vld_d;
      s2_err_q    <= s2_err_d;
      s2_c0_q     <= s2_c0_d;
      s2_prodsh_q <= s2_prodsh_d;
      pushout_q   <= pushout_d;
      e_q         <= e_d;
      e_err_q     <= e_err_d;
    end
  end

  assign bus.tbl_ready = tbl_ready_q;
  assign bus.pushout   = pushout_q;
  assign bus.e         = e_q;
  assign bus.e_err     = e_err_q;
endmodule

// File: tb/tb_ln_interp.sv
// Bench for ln_interp: vector table with hand-computed results, a reference model for
// streamed traffic, and a negedge monitor checking pushout timing and results in order.
module tb_ln_interp;
  logic clk;
  logic rst;
  ln_interp_if bus ();

  ln_interp dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  logic [64:0] exp_q[$];
  logic [63:0] m_t0 [512];
  logic [63:0] m_t1 [512];
  logic        m_ready = 1'b0;

  typedef struct {
    logic [8:0]  idx;
    logic [63:0] delta;
    logic [63:0] c0;
    logic [63:0] c1;
    logic [63:0] exp_e;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_e(input logic [63:0] c0, input logic [63:0] c1,
                                          input logic [63:0] dl);
    logic [118:0] p;
    logic [63:0]  sh;
    p  = 119'(c1) * 119'(dl[54:0]);
    sh = p[118:55];
    return (sh > c0) ? 64'd0 : c0 - sh;
  endfunction

  // One cycle: optional sample and optional table write, driven just after the rising edge.
  task automatic step(input logic p, input logic [8:0] idx, input logic [63:0] dl,
                      input logic w, input logic [8:0] wa, input logic [63:0] c0,
                      input logic [63:0] c1, input logic use_model, input logic [64:0] exp_in);
    if (p) begin
      if (use_model) exp_q.push_back({~m_ready, model_e(m_t0[idx], m_t1[idx], dl)});
      else           exp_q.push_back(exp_in);
    end
    if (w) begin
      m_t0[wa] = c0;
      m_t1[wa] = c1;
      if (wa == 9'd511) m_ready = 1'b1;
    end
    bus.pushin       = p;
    bus.fract_lt     = idx;
    bus.delta_denorm = dl;
    bus.twr          = w;
    bus.taddr        = wa;
    bus.tc0          = c0;
    bus.tc1          = c1;
    @(posedge clk); #1;
    bus.pushin = 1'b0;
    bus.twr    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 65'(exp_q.size()), 65'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pushout"},   65'(bus.pushout),   65'd0);
    chk({tag, "_e"},         65'(bus.e),         65'd0);
    chk({tag, "_e_err"},     65'(bus.e_err),     65'd0);
    chk({tag, "_tbl_ready"}, 65'(bus.tbl_ready), 65'd0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Monitor: pushout must equal pushin seen three falling edges earlier; results pop in order.
  logic        hist [3];
  logic [63:0] last_e;
  always @(negedge clk) begin
    logic [64:0] exp;
    if (rst) begin
      hist[0] = 1'b0; hist[1] = 1'b0; hist[2] = 1'b0;
      last_e  = '0;
    end else begin
      chk("pushout_timing", 65'(bus.pushout), 65'(hist[2]));
      if (bus.pushout) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pushout", 65'(bus.pushout), 65'd0);
        end else begin
          exp = exp_q.pop_front();
          chk("e", 65'(bus.e), 65'(exp[63:0]));
          chk("e_err", 65'(bus.e_err), 65'(exp[64]));
        end
        last_e = bus.e;
      end else begin
        chk("e_hold", 65'(bus.e), 65'(last_e));
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = bus.pushin;
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{9'd3,  64'h0040_0000_0000_0000, 64'h0100_0000_0000_0000, 64'h0100_0000_0000_0000, 64'h0080_0000_0000_0000};
    vecs[1] = '{9'd3,  64'h0000_0000_0000_0000, 64'h0100_0000_0000_0000, 64'h0100_0000_0000_0000, 64'h0100_0000_0000_0000};
    vecs[2] = '{9'd3,  64'h007F_FFFF_FFFF_FFFF, 64'h0100_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000};
    vecs[3] = '{9'd10, 64'h0020_0000_0000_0000, 64'h0100_0000_0000_0000, 64'h0100_0000_0000_0000, 64'h00C0_0000_0000_0000};
    vecs[4] = '{9'd20, 64'h0040_0000_0000_0000, 64'h0080_0000_0000_0000, 64'h0100_0000_0000_0000, 64'h0000_0000_0000_0000};
    vecs[5] = '{9'd30, 64'hFFC0_0000_0000_0000, 64'h0100_0000_0000_0000, 64'h0100_0000_0000_0000, 64'h0080_0000_0000_0000};
    vecs[6] = '{9'd40, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0005, 64'h0080_0000_0000_0000, 64'h0000_0000_0000_0004};
    vecs[7] = '{9'd50, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0005, 64'h007F_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0003};
    vecs[8] = '{9'd60, 64'h007F_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0100_0000_0000_0000, 64'hFF00_0000_0000_0001};

    rst = 1'b0;
    bus.pushin = 1'b0; bus.fract_lt = '0; bus.delta_denorm = '0;
    bus.twr = 1'b0; bus.taddr = '0; bus.tc0 = '0; bus.tc1 = '0;

    // Asynchronous reset before any clock edge.
    #3 rst = 1'b1;
    #1 check_reset_outputs("reset_async");
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(4);
    check_reset_outputs("reset_idle");

    // Samples before the table is complete carry e_err.
    step(0, 0, 0, 1, 9'd5, 64'h0000_0000_0000_1234, 64'd0, 0, 0);
    step(1, 9'd5, 64'h0012_3456_789A_BCDE, 0, 0, 0, 0, 0, {1'b1, 64'h0000_0000_0000_1234});
    drain("drain_unloaded");

    for (int i = 0; i < 511; i++) begin
      if (i == 7) step(0, 0, 0, 1, 9'(i), 64'h1111_2222_3333_4444, rnd64(), 1, 0);
      else        step(0, 0, 0, 1, 9'(i), rnd64(), rnd64(), 1, 0);
    end
    chk("tbl_ready_before_511", 65'(bus.tbl_ready), 65'd0);
    // Final write shares a cycle with a sample: that sample is still flagged, the next is not.
    step(1, 9'd5, rnd64(), 1, 9'd511, rnd64(), rnd64(), 1, 0);
    chk("tbl_ready_after_511", 65'(bus.tbl_ready), 65'd1);
    step(1, 9'd5, rnd64(), 0, 0, 0, 0, 1, 0);
    drain("drain_load");

    // Hand-computed vectors.
    foreach (vecs[k]) begin
      step(0, 0, 0, 1, vecs[k].idx, vecs[k].c0, vecs[k].c1, 0, 0);
      step(1, vecs[k].idx, vecs[k].delta, 0, 0, 0, 0, 0, {1'b0, vecs[k].exp_e});
    end
    drain("drain_vectors");

    // Same-cycle write and read of idx 7 returns the old entry; the next sample sees the new one.
    step(1, 9'd7, 64'd0, 1, 9'd7, 64'h5555_6666_7777_8888, 64'd99, 0, {1'b0, 64'h1111_2222_3333_4444});
    step(1, 9'd7, 64'd0, 0, 0, 0, 0, 0, {1'b0, 64'h5555_6666_7777_8888});
    drain("drain_bypass");

    // 512 back-to-back samples across the whole table.
    for (int i = 0; i < 512; i++) step(1, 9'(i), rnd64(), 0, 0, 0, 0, 1, 0);
    // Random gaps with occasional interleaved writes.
    for (int i = 0; i < 300; i++) begin
      logic p, w;
      p = 1'($urandom_range(0, 1));
      w = ($urandom_range(0, 7) == 0);
      step(p, 9'($urandom_range(0, 511)), rnd64(), w, 9'($urandom_range(0, 510)),
           rnd64(), rnd64(), 1, 0);
    end
    drain("drain_stream");

    // Reset with samples in flight: outputs clear at once, nothing emerges afterwards.
    step(1, 9'd10, 64'h0020_0000_0000_0000, 0, 0, 0, 0, 1, 0);
    step(1, 9'd10, 64'h0020_0000_0000_0000, 0, 0, 0, 0, 1, 0);
    step(1, 9'd10, 64'h0020_0000_0000_0000, 0, 0, 0, 0, 1, 0);
    #2;
    rst = 1'b1;
    exp_q.delete();
    m_ready = 1'b0;
    #1 check_reset_outputs("reset_midstream");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(6);
    check_reset_outputs("reset_after_release");
    // Table contents survive reset but tbl_ready must be re-earned.
    step(1, 9'd10, 64'h0020_0000_0000_0000, 0, 0, 0, 0, 0, {1'b1, 64'h00C0_0000_0000_0000});
    drain("drain_after_reset");
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
